// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: synchronised and glitch-filtered clock, 11-bit frame decode, scancode queue.
// Define PS2_RX_FIFO_EN for a 4-entry FIFO queue; otherwise a single holding register is used.
module ps2_rx #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 5000
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_n_i,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] dat_o,
    output logic       rdy_o,
    input  logic       ack_i,
    output logic       err_o,
    output logic       ovf_o,
    input  logic       clr_i
);
    localparam int FW = $clog2(FILTER + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    logic [1:0]    clk_sync_reg;
    logic [1:0]    data_sync_reg;
    logic          clk_s;
    logic          data_s;
    logic          filt_clk_reg;
    logic [FW-1:0] filt_cnt_reg;
    logic          fall;

    logic [1:0]    state_reg;
    logic [2:0]    bit_cnt_reg;
    logic [7:0]    shift_reg;
    logic          par_ok_reg;
    logic [TW-1:0] to_cnt_reg;
    logic          push_reg;
    logic [7:0]    push_data_reg;
    logic          err_reg;

    logic          pop;
    logic          full;
    logic          wr_en;
    logic          ovf_set;
    logic          ovf_reg;

    assign clk_s  = clk_sync_reg[1];
    assign data_s = data_sync_reg[1];

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            clk_sync_reg  <= 2'b11;
            data_sync_reg <= 2'b11;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
            data_sync_reg <= {data_sync_reg[0], ps2_data};
        end
    end

    // The level flips on the FILTER-th consecutive differing sample; that same cycle is the edge.
    assign fall = filt_clk_reg && !clk_s && (filt_cnt_reg == FW'(FILTER - 1));

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            filt_clk_reg <= 1'b1;
            filt_cnt_reg <= '0;
        end else if (clk_s == filt_clk_reg) begin
            filt_cnt_reg <= '0;
        end else if (filt_cnt_reg == FW'(FILTER - 1)) begin
            filt_clk_reg <= clk_s;
            filt_cnt_reg <= '0;
        end else begin
            filt_cnt_reg <= filt_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            par_ok_reg    <= 1'b0;
            to_cnt_reg    <= '0;
            push_reg      <= 1'b0;
            push_data_reg <= '0;
            err_reg       <= 1'b0;
        end else begin
            push_reg <= 1'b0;
            err_reg  <= 1'b0;
            if (fall) begin
                to_cnt_reg <= '0;
                case (state_reg)
                    IDLE: begin
                        if (!data_s) begin
                            state_reg   <= DATA;
                            bit_cnt_reg <= '0;
                        end
                    end
                    DATA: begin
                        shift_reg   <= {data_s, shift_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg == 3'd7)
                            state_reg <= PARITY;
                    end
                    PARITY: begin
                        par_ok_reg <= ^{shift_reg, data_s};
                        state_reg  <= STOP;
                    end
                    default: begin
                        if (data_s && par_ok_reg) begin
                            push_reg      <= 1'b1;
                            push_data_reg <= shift_reg;
                        end else begin
                            err_reg <= 1'b1;
                        end
                        state_reg <= IDLE;
                    end
                endcase
            end else if (state_reg != IDLE) begin
                if (to_cnt_reg == TW'(TIMEOUT - 1)) begin
                    err_reg    <= 1'b1;
                    state_reg  <= IDLE;
                    to_cnt_reg <= '0;
                end else begin
                    to_cnt_reg <= to_cnt_reg + 1'b1;
                end
            end else begin
                to_cnt_reg <= '0;
            end
        end
    end

    // A pop in the push cycle frees a slot, so a full queue still accepts the byte.
    assign pop     = ack_i && rdy_o;
    assign wr_en   = push_reg && (!full || pop);
    assign ovf_set = push_reg && full && !pop;

`ifdef PS2_RX_FIFO_EN
    logic [7:0] mem [0:3];
    logic [1:0] wr_ptr_reg;
    logic [1:0] rd_ptr_reg;
    logic [2:0] count_reg;

    always_ff @(posedge wb_clk_i) begin
        if (wr_en)
            mem[wr_ptr_reg] <= push_data_reg;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({wr_en, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rdy_o = (count_reg != 3'd0);
    assign full  = (count_reg == 3'd4);
    assign dat_o = rdy_o ? mem[rd_ptr_reg] : 8'h00;
`else
    logic [7:0] hold_reg;
    logic       valid_reg;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            hold_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (wr_en) begin
            hold_reg  <= push_data_reg;
            valid_reg <= 1'b1;
        end else if (pop) begin
            valid_reg <= 1'b0;
        end
    end

    assign rdy_o = valid_reg;
    assign full  = valid_reg;
    assign dat_o = valid_reg ? hold_reg : 8'h00;
`endif

    // An overflow in the same cycle as clr_i wins.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i)
            ovf_reg <= 1'b0;
        else if (ovf_set)
            ovf_reg <= 1'b1;
        else if (clr_i)
            ovf_reg <= 1'b0;
    end

    assign ovf_o = ovf_reg;
    assign err_o = err_reg;
endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: directed scenarios plus randomized frames against a queue model.
// Honors PS2_RX_FIFO_EN to select the expected queue depth.
module tb_ps2_rx;
    localparam int FILTER  = 8;
    localparam int TIMEOUT = 5000;
`ifdef PS2_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       ack = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] dat_o;
    logic       rdy_o;
    logic       err_o;
    logic       ovf_o;

    int         checks = 0;
    int         failures = 0;
    longint     cyc = 0;
    int         err_hi = 0;
    longint     err_cyc = 0;
    longint     last_fall = 0;
    logic [7:0] model_q[$];
    logic       model_ovf = 1'b0;

    ps2_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i  (clk),
        .wb_rst_n_i(rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .dat_o     (dat_o),
        .rdy_o     (rdy_o),
        .ack_i     (ack),
        .err_o     (err_o),
        .ovf_o     (ovf_o),
        .clr_i     (clr)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (err_o) begin
            err_hi  <= err_hi + 1;
            err_cyc <= cyc;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // pulse: 0 none, 1 ack_i, 2 clr_i, timed to the cycle the stop-bit byte is written
    task automatic send_bit(input logic b, input int pulse, output int lat);
        ps2_data = b;
        wait_cyc(20);
        ps2_clk   = 1'b0;
        last_fall = cyc;
        lat       = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            ack = (pulse == 1 && i == FILTER + 2);
            clr = (pulse == 2 && i == FILTER + 2);
            if (lat < 0 && rdy_o) lat = i;
        end
        ps2_clk = 1'b1;
        wait_cyc(20);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop,
                              input int pulse, output int lat);
        logic p;
        int   l;
        p = ~(^d) ^ par_flip;
        send_bit(1'b0, 0, l);
        for (int i = 0; i < 8; i++) send_bit(d[i], 0, l);
        send_bit(p, 0, l);
        send_bit(stop, pulse, lat);
    endtask

    // Reference model: a good frame enters the queue if there is room (after a simultaneous pop).
    task automatic model_frame(input logic [7:0] d, input logic good, input int pulse);
        logic ov;
        ov = 1'b0;
        if (good) begin
            if (pulse == 1 && model_q.size() > 0) void'(model_q.pop_front());
            if (model_q.size() < DEPTH) model_q.push_back(d);
            else ov = 1'b1;
        end
        if (ov) model_ovf = 1'b1;
        else if (pulse == 2) model_ovf = 1'b0;
    endtask

    task automatic pop_one();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        if (model_q.size() > 0) void'(model_q.pop_front());
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_ovf = 1'b0;
    endtask

    task automatic drain(input string name);
        while (model_q.size() > 0) begin
            checks++;
            if (rdy_o !== 1'b1 || dat_o !== model_q[0]) begin
                failures++;
                $display("FAIL %s_pop got rdy=%b dat=%h expected rdy=1 dat=%h", name, rdy_o, dat_o, model_q[0]);
            end
            pop_one();
        end
        checks++;
        if (rdy_o !== 1'b0 || dat_o !== 8'h00) begin
            failures++;
            $display("FAIL %s_empty got rdy=%b dat=%h expected rdy=0 dat=00", name, rdy_o, dat_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_cyc(3);
        checks++;
        if ({dat_o, rdy_o, err_o, ovf_o} !== 11'h0) begin
            failures++;
            $display("FAIL reset got dat=%h rdy=%b err=%b ovf=%b expected all 0", dat_o, rdy_o, err_o, ovf_o);
        end
        rst_n = 1'b1;
        wait_cyc(5);
        $display("test_reset done");
    endtask

    task automatic test_basic();
        int lat;
        int e0;
        e0 = err_hi;
        send_frame(8'h1C, 1'b0, 1'b1, 0, lat);
        model_frame(8'h1C, 1'b1, 0);
        checks++;
        if (lat < FILTER + 2 || lat > FILTER + 5) begin
            failures++;
            $display("FAIL basic_latency got %0d expected %0d..%0d", lat, FILTER + 2, FILTER + 5);
        end
        checks++;
        if (rdy_o !== 1'b1 || dat_o !== 8'h1C || err_hi !== e0) begin
            failures++;
            $display("FAIL basic_rx got rdy=%b dat=%h errs=%0d expected rdy=1 dat=1c errs=0", rdy_o, dat_o, err_hi - e0);
        end
        drain("basic");
        $display("test_basic frame=1c latency=%0d", lat);
    endtask

    task automatic test_parity_err();
        int lat;
        int e0;
        e0 = err_hi;
        send_frame(8'h1C, 1'b1, 1'b1, 0, lat);
        checks++;
        if (err_hi - e0 !== 1 || rdy_o !== 1'b0) begin
            failures++;
            $display("FAIL parity_err got err_cycles=%0d rdy=%b expected 1 and 0", err_hi - e0, rdy_o);
        end
        $display("test_parity_err err_cycles=%0d", err_hi - e0);
    endtask

    task automatic test_timeout();
        int     l;
        int     e0;
        longint dt;
        e0 = err_hi;
        send_bit(1'b0, 0, l);
        send_bit(1'b1, 0, l);
        send_bit(1'b0, 0, l);
        send_bit(1'b1, 0, l);
        wait_cyc(6000);
        dt = err_cyc - last_fall;
        checks++;
        if (err_hi - e0 !== 1) begin
            failures++;
            $display("FAIL timeout_err got err_cycles=%0d expected 1", err_hi - e0);
        end
        checks++;
        if (dt < TIMEOUT || dt > TIMEOUT + FILTER + 6) begin
            failures++;
            $display("FAIL timeout_cycle got %0d expected %0d..%0d", dt, TIMEOUT, TIMEOUT + FILTER + 6);
        end
        send_frame(8'h5A, 1'b0, 1'b1, 0, l);
        model_frame(8'h5A, 1'b1, 0);
        drain("timeout_next");
        $display("test_timeout err_after=%0d", dt);
    endtask

    task automatic test_glitch();
        int l;
        int e0;
        e0 = err_hi;
        ps2_data = 1'b0;
        wait_cyc(20);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(100);
        checks++;
        if (err_hi !== e0 || rdy_o !== 1'b0) begin
            failures++;
            $display("FAIL glitch_idle got errs=%0d rdy=%b expected 0 and 0", err_hi - e0, rdy_o);
        end
        send_frame(8'h3C, 1'b0, 1'b1, 0, l);
        model_frame(8'h3C, 1'b1, 0);
        checks++;
        if (err_hi !== e0) begin
            failures++;
            $display("FAIL glitch_frame_err got errs=%0d expected 0", err_hi - e0);
        end
        drain("glitch");
        $display("test_glitch done");
    endtask

    task automatic test_overflow();
        int l;
        for (int i = 1; i <= DEPTH + 1; i++) begin
            send_frame(8'(i), 1'b0, 1'b1, 0, l);
            model_frame(8'(i), 1'b1, 0);
        end
        checks++;
        if (ovf_o !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set got %b expected 1", ovf_o);
        end
        drain("ovf");
        clr_pulse();
        checks++;
        if (ovf_o !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clr got %b expected 0", ovf_o);
        end
        for (int i = 0; i < DEPTH; i++) begin
            send_frame(8'h40 + 8'(i), 1'b0, 1'b1, 0, l);
            model_frame(8'h40 + 8'(i), 1'b1, 0);
        end
        send_frame(8'h77, 1'b0, 1'b1, 2, l);
        model_frame(8'h77, 1'b1, 2);
        checks++;
        if (ovf_o !== model_ovf) begin
            failures++;
            $display("FAIL ovf_vs_clr got %b expected %b", ovf_o, model_ovf);
        end
        drain("ovf_clr");
        clr_pulse();
        $display("test_overflow depth=%0d", DEPTH);
    endtask

    task automatic test_back_to_back();
        int l;
        for (int i = 0; i < DEPTH; i++) begin
            send_frame(8'hA0 + 8'(i), 1'b0, 1'b1, 0, l);
            model_frame(8'hA0 + 8'(i), 1'b1, 0);
        end
        send_frame(8'hEE, 1'b0, 1'b1, 1, l);
        model_frame(8'hEE, 1'b1, 1);
        checks++;
        if (ovf_o !== 1'b0) begin
            failures++;
            $display("FAIL pushpop_full_ovf got %b expected 0", ovf_o);
        end
        drain("pushpop_full");
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid();
        int l;
        int e0;
        send_frame(8'h11, 1'b0, 1'b1, 0, l);
        e0 = err_hi;
        send_bit(1'b0, 0, l);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0, l);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_q.delete();
        model_ovf = 1'b0;
        checks++;
        if ({dat_o, rdy_o, err_o, ovf_o} !== 11'h0) begin
            failures++;
            $display("FAIL reset_mid got dat=%h rdy=%b err=%b ovf=%b expected all 0", dat_o, rdy_o, err_o, ovf_o);
        end
        wait_cyc(20);
        send_frame(8'hF0, 1'b0, 1'b1, 0, l);
        model_frame(8'hF0, 1'b1, 0);
        checks++;
        if (err_hi !== e0) begin
            failures++;
            $display("FAIL reset_mid_err got errs=%0d expected 0", err_hi - e0);
        end
        drain("reset_mid");
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        int         l;
        int         e0;
        logic [7:0] d;
        logic       pf;
        logic       stp;
        logic       good;
        for (int n = 0; n < 12; n++) begin
            d    = 8'($urandom_range(0, 255));
            pf   = ($urandom_range(0, 3) == 0);
            stp  = ($urandom_range(0, 7) != 0);
            good = !pf && stp;
            e0   = err_hi;
            send_frame(d, pf, stp, 0, l);
            model_frame(d, good, 0);
            checks++;
            if (err_hi - e0 !== (good ? 0 : 1) || rdy_o !== (model_q.size() > 0) ||
                dat_o !== (model_q.size() > 0 ? model_q[0] : 8'h00) || ovf_o !== model_ovf) begin
                failures++;
                $display("FAIL random_%0d got errs=%0d rdy=%b dat=%h ovf=%b expected errs=%0d rdy=%b dat=%h ovf=%b",
                         n, err_hi - e0, rdy_o, dat_o, ovf_o, good ? 0 : 1, model_q.size() > 0,
                         model_q.size() > 0 ? model_q[0] : 8'h00, model_ovf);
            end
            $display("random frame %0d data=%h par_flip=%b stop=%b queued=%0d", n, d, pf, stp, model_q.size());
            if ($urandom_range(0, 1) == 1 && model_q.size() > 0) pop_one();
        end
        drain("random");
        clr_pulse();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity_err();
        test_timeout();
        test_glitch();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 FILTER, 8, number of consecutive identical synchronised samples required to accept a new ps2_clk level.
REQ-002 TIMEOUT, 5000, clock cycles without a ps2_clk falling edge before a partial frame is aborted (100 us at 50 MHz).
REQ-003 wb_clk_i  input  1  system clock (50 MHz); the only clock in the block.
REQ-004 wb_rst_n_i  input  1  reset, synchronous, active-low.
REQ-005 ps2_clk  input  1  keyboard clock, asynchronous.
REQ-006 ps2_data  input  1  keyboard data, asynchronous.
REQ-007 dat_o  output  8  received scancode at the head of the queue.
REQ-008 rdy_o  output  1  high while the queue is not empty.
REQ-009 ack_i  input  1  single-cycle pop request; ignored while rdy_o is low.
REQ-010 err_o  output  1  one-cycle pulse on a parity, stop-bit or timeout error.
REQ-011 ovf_o  output  1  sticky overflow flag.
REQ-012 clr_i  input  1  clears ovf_o.

Function
REQ-013 ps2_clk and ps2_data SHALL each pass through a 2-flop synchroniser.
REQ-014 The filtered clock SHALL change level only after FILTER consecutive equal synchronised samples; shorter glitches SHALL be ignored.
REQ-015 A falling edge of the filtered clock SHALL sample the synchronised ps2_data in the same cycle.
REQ-016 FSM states: IDLE, DATA, PARITY, STOP.
REQ-017 IDLE: a sampled 0 SHALL go to DATA with the bit counter at 0; a sampled 1 SHALL stay in IDLE with no error.
REQ-018 DATA: shift 8 bits, LSB first; after bit 7, go to PARITY.
REQ-019 PARITY: odd parity over the 8 data bits plus the parity bit SHALL be checked, then go to STOP.
REQ-020 STOP: on sample 1 with good parity, push the byte; otherwise pulse err_o and discard. Go to IDLE in both cases.
REQ-021 Timeout counter: clears on every filtered falling edge. In any state other than IDLE, reaching TIMEOUT SHALL pulse err_o and return to IDLE.
REQ-022 Push latency: the byte is written on the clock after the stop-bit edge; rdy_o and dat_o are valid one clock later.
REQ-023 Pop: ack_i with rdy_o high removes the head byte; dat_o shows the next entry on the following clock.
REQ-024 Push and pop in the same cycle SHALL both succeed, including when the queue is full; ovf_o SHALL NOT set.
REQ-025 Push when the queue is full without a pop SHALL drop the new byte and set ovf_o; stored data is unchanged.
REQ-026 clr_i SHALL clear ovf_o. If clr_i and an overflow occur in the same cycle, ovf_o SHALL be set.
REQ-027 dat_o SHALL read 8'h00 while the queue is empty.

Reset
REQ-028 When wb_rst_n_i=0 at a clock edge, all of the following SHALL be cleared:
- FSM to IDLE;
- bit counter, timeout counter and queue pointers to 0;
- dat_o=8'h00, rdy_o=0, err_o=0, ovf_o=0;
- filtered clock and synchronisers set to 1.
REQ-029 Reset mid-frame SHALL discard the partial frame; no push and no err_o.

Configuration
REQ-030 Macro PS2_RX_FIFO_EN:
- defined: the queue is a 4-entry circular FIFO with 2-bit wrapping pointers and a 3-bit count;
- undefined: the queue is a single holding register (depth 1).
All other behaviour SHALL be identical, including full/overflow and simultaneous push/pop rules.

Verification
REQ-031 Frame 8'h1C (parity 0, stop 1), then ack_i -> dat_o=8'h1C with rdy_o=1 two clocks after the stop edge; after ack_i, rdy_o=0.
REQ-032 Frame 8'h1C with parity bit 1 -> err_o pulses exactly once; rdy_o stays 0.
REQ-033 Start bit and 3 data bits sent, then ps2_clk held high for 6000 cycles -> err_o pulses at cycle 5000; next full frame 8'h5A is received correctly.
REQ-034 With FIFO_EN, 5 frames 8'h01..8'h05 and no ack_i:
- ovf_o=1;
- pops return 01, 02, 03, 04;
- clr_i clears ovf_o.
Without FIFO_EN, the second frame sets ovf_o and the pop returns 01.
REQ-035 3-cycle low glitch on ps2_clk while IDLE with ps2_data=0 -> no state change, no err_o.
REQ-036 wb_rst_n_i=0 for 1 clock after bit 4 of a frame -> all outputs 0; next frame 8'hF0 is received correctly.
